// File: rtl/alu_pkg.sv
// Shared types for the ALU sweep stage: widths, sequencer states and FIFO entry layout.
package alu_pkg;
    localparam int unsigned OP_W   = 5;
    localparam int unsigned DATA_W = 32;

    typedef enum logic [1:0] {
        IDLE,
        DRIVE,
        CAPTURE,
        DONE
    } state_t;

    typedef struct packed {
        logic [OP_W-1:0]   op;
        logic [DATA_W-1:0] data;
    } res_t;
endpackage

// File: rtl/sync_fifo.sv
// First-word-fall-through synchronous FIFO; pointers carry one extra wrap bit for full/empty.
module sync_fifo #(
    parameter int unsigned WIDTH = 37,
    parameter int unsigned DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    output logic             full,
    input  logic             pop,
    output logic [WIDTH-1:0] dout,
    output logic             empty
);
    localparam int unsigned AW = $clog2(DEPTH);
    localparam logic [AW:0] PTR_ONE = (AW+1)'(1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wptr;
    logic [AW:0]      rptr;
    logic             do_push;
    logic             do_pop;

    assign empty   = (wptr == rptr);
    assign full    = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign dout    = mem[rptr[AW-1:0]];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr <= '0;
            rptr <= '0;
        end else begin
            if (do_push) wptr <= wptr + PTR_ONE;
            if (do_pop)  rptr <= rptr + PTR_ONE;
        end
    end

    // Storage needs no reset: empty pointers hide stale contents.
    always_ff @(posedge clk) begin
        if (do_push) mem[wptr[AW-1:0]] <= din;
    end
endmodule

// File: rtl/alu_sweep.sv
// Sequencer that steps an external ALU through an op range, holding inputs SETTLE cycles
// per op and queueing each tagged result for a valid/ready consumer.
module alu_sweep
    import alu_pkg::*;
#(
    parameter int unsigned SETTLE = 1,
    parameter int unsigned DEPTH  = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [DATA_W-1:0] cmd_a,
    input  logic [DATA_W-1:0] cmd_b,
    input  logic [OP_W-1:0]   op_first,
    input  logic [OP_W-1:0]   op_last,
    output logic [DATA_W-1:0] alu_a,
    output logic [DATA_W-1:0] alu_b,
    output logic [OP_W-1:0]   alu_op,
    input  logic [DATA_W-1:0] alu_out,
    output logic              res_valid,
    input  logic              res_ready,
    output logic [DATA_W-1:0] res_data,
    output logic [OP_W-1:0]   res_op,
    output logic              busy,
    output logic              done,
    output logic [5:0]        count
);
    localparam logic [3:0] SETTLE_LD = 4'(SETTLE - 1);

    state_t          state;
    state_t          state_nx;
    logic [OP_W-1:0] op_end;
    logic [3:0]      settle_cnt;
    logic            fifo_full;
    logic            fifo_empty;
    logic            push;
    res_t            head;
    res_t            entry;

    assign push  = (state == CAPTURE) && !fifo_full;
    assign entry = '{op: alu_op, data: alu_out};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (start) state_nx = (op_first > op_last) ? DONE : DRIVE;
            DRIVE:   if (settle_cnt == 4'd0) state_nx = CAPTURE;
            CAPTURE: if (!fifo_full) state_nx = (alu_op == op_end) ? DONE : DRIVE;
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            alu_a      <= '0;
            alu_b      <= '0;
            alu_op     <= '0;
            op_end     <= '0;
            count      <= '0;
            settle_cnt <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        alu_a      <= cmd_a;
                        alu_b      <= cmd_b;
                        alu_op     <= op_first;
                        op_end     <= op_last;
                        count      <= '0;
                        settle_cnt <= SETTLE_LD;
                    end
                end
                DRIVE: begin
                    if (settle_cnt != 4'd0) settle_cnt <= settle_cnt - 4'd1;
                end
                CAPTURE: begin
                    // Equality end test keeps op 31 from wrapping to 0.
                    if (!fifo_full) begin
                        count <= count + 6'd1;
                        if (alu_op != op_end) begin
                            alu_op     <= alu_op + 5'd1;
                            settle_cnt <= SETTLE_LD;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    sync_fifo #(
        .WIDTH ($bits(res_t)),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push),
        .din   (entry),
        .full  (fifo_full),
        .pop   (res_valid && res_ready),
        .dout  (head),
        .empty (fifo_empty)
    );

    assign res_valid = !fifo_empty;
    assign res_data  = res_valid ? head.data : '0;
    assign res_op    = res_valid ? head.op   : '0;
    assign busy      = (state != IDLE);
    assign done      = (state == DONE);
endmodule

// File: tb/tb_alu_sweep.sv
// Bench for alu_sweep: stub ALU (a+b+op), queue-based expected-result model, directed and random sweeps.
module tb_alu_sweep;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [31:0] cmd_a, cmd_b;
    logic [4:0]  op_first, op_last;
    logic [31:0] alu_a, alu_b, alu_out;
    logic [4:0]  alu_op;
    logic        res_valid, res_ready;
    logic [31:0] res_data;
    logic [4:0]  res_op;
    logic        busy, done;
    logic [5:0]  count;

    logic        s3_start;
    logic [31:0] s3_alu_a, s3_alu_b, s3_alu_out, s3_res_data;
    logic [4:0]  s3_alu_op, s3_res_op;
    logic        s3_res_valid, s3_busy, s3_done;
    logic [5:0]  s3_count;

    int          checks = 0;
    int          errors = 0;
    logic [36:0] exp_q[$];

    always #5 clk = ~clk;

    assign alu_out    = alu_a + alu_b + 32'(alu_op);
    assign s3_alu_out = s3_alu_a + s3_alu_b + 32'(s3_alu_op);

    alu_sweep #(.SETTLE(1), .DEPTH(4)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .cmd_a(cmd_a), .cmd_b(cmd_b),
        .op_first(op_first), .op_last(op_last), .alu_a(alu_a), .alu_b(alu_b),
        .alu_op(alu_op), .alu_out(alu_out), .res_valid(res_valid), .res_ready(res_ready),
        .res_data(res_data), .res_op(res_op), .busy(busy), .done(done), .count(count)
    );

    alu_sweep #(.SETTLE(3), .DEPTH(4)) dut3 (
        .clk(clk), .rst_n(rst_n), .start(s3_start), .cmd_a(32'd0), .cmd_b(32'd0),
        .op_first(5'd0), .op_last(5'd3), .alu_a(s3_alu_a), .alu_b(s3_alu_b),
        .alu_op(s3_alu_op), .alu_out(s3_alu_out), .res_valid(s3_res_valid), .res_ready(1'b1),
        .res_data(s3_res_data), .res_op(s3_res_op), .busy(s3_busy), .done(s3_done), .count(s3_count)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Every accepted beat must match the oldest outstanding expected result.
    always @(negedge clk) begin
        if (rst_n && res_valid && res_ready) begin
            if (exp_q.size() == 0) chk("unexpected_result", {27'd0, res_op, res_data}, 64'hdead);
            else chk("result", {27'd0, res_op, res_data}, {27'd0, exp_q.pop_front()});
        end
    end

    task automatic kick(input logic [31:0] a, input logic [31:0] b, input int f, input int l);
        start    = 1'b1;
        cmd_a    = a;
        cmd_b    = b;
        op_first = 5'(f);
        op_last  = 5'(l);
        for (int op = f; op <= l; op++) exp_q.push_back({5'(op), a + b + 32'(op)});
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic wait_done(output int n, input bit rnd);
        n = 1;
        while (!done && n < 300) begin
            if (rnd) res_ready = 1'($urandom_range(0, 1));
            @(posedge clk); #1;
            n++;
        end
        chk("done_seen", {63'd0, done}, 64'd1);
    endtask

    task automatic drain();
        res_ready = 1'b1;
        for (int i = 0; i < 40 && res_valid; i++) begin
            @(posedge clk); #1;
        end
        chk("queue_empty", 64'(exp_q.size()), 64'd0);
        chk("valid_low_after_drain", {63'd0, res_valid}, 64'd0);
    endtask

    initial begin
        int n, f, l, prev, first_t, last_t, nchg;
        logic [31:0] ra, rb;
        rst_n = 1'b1; start = 1'b0; s3_start = 1'b0; res_ready = 1'b0;
        cmd_a = '0; cmd_b = '0; op_first = '0; op_last = '0;
        #2 rst_n = 1'b0;
        #1;
        chk("rst_busy", {63'd0, busy}, 64'd0);
        chk("rst_done", {63'd0, done}, 64'd0);
        chk("rst_valid", {63'd0, res_valid}, 64'd0);
        chk("rst_alu_op", 64'(alu_op), 64'd0);
        chk("rst_count", 64'(count), 64'd0);
        chk("rst_alu_a", 64'(alu_a), 64'd0);
        @(posedge clk); #1 rst_n = 1'b1;
        @(posedge clk); #1;

        res_ready = 1'b1;
        kick(32'd3, 32'd2, 0, 7);
        wait_done(n, 1'b0);
        chk("basic_done_latency", 64'(n), 64'd17);
        chk("basic_count", 64'(count), 64'd8);
        @(posedge clk); #1;
        chk("basic_idle_busy", {63'd0, busy}, 64'd0);
        drain();

        kick(32'd3, 32'd2, 0, 7);
        repeat (3) begin @(posedge clk); #1; end
        start = 1'b1; cmd_a = 32'd100; cmd_b = 32'd50; op_first = 5'd0; op_last = 5'd1;
        @(posedge clk); #1 start = 1'b0;
        wait_done(n, 1'b0);
        chk("ignored_start_count", 64'(count), 64'd8);
        chk("ignored_start_alu_a", 64'(alu_a), 64'd3);
        drain();

        res_ready = 1'b0;
        kick(32'd3, 32'd2, 0, 7);
        repeat (30) begin @(posedge clk); #1; end
        chk("bp_busy", {63'd0, busy}, 64'd1);
        chk("bp_alu_op", 64'(alu_op), 64'd4);
        chk("bp_count", 64'(count), 64'd4);
        chk("bp_valid", {63'd0, res_valid}, 64'd1);
        res_ready = 1'b1;
        wait_done(n, 1'b0);
        chk("bp_final_count", 64'(count), 64'd8);
        drain();

        kick(32'd1, 32'd1, 9, 3);
        wait_done(n, 1'b0);
        chk("empty_done_latency", 64'(n), 64'd1);
        chk("empty_count", 64'(count), 64'd0);
        repeat (3) begin @(posedge clk); #1; end
        chk("empty_no_valid", {63'd0, res_valid}, 64'd0);

        res_ready = 1'b0;
        kick(32'd0, 32'd0, 31, 31);
        wait_done(n, 1'b0);
        repeat (5) begin @(posedge clk); #1; end
        chk("op31_hold", 64'(alu_op), 64'd31);
        chk("op31_count", 64'(count), 64'd1);
        drain();

        for (int k = 0; k < 6; k++) begin
            ra = $urandom; rb = $urandom;
            f  = int'($urandom_range(0, 31));
            l  = int'($urandom_range(f, (f + 9 > 31) ? 31 : f + 9));
            kick(ra, rb, f, l);
            wait_done(n, 1'b1);
            chk("rand_count", 64'(count), 64'(l - f + 1));
            drain();
        end

        res_ready = 1'b1;
        kick(32'd3, 32'd2, 0, 7);
        for (int i = 0; i < 40 && alu_op != 5'd2; i++) begin @(posedge clk); #1; end
        res_ready = 1'b0;
        for (int i = 0; i < 40 && alu_op != 5'd4; i++) begin @(posedge clk); #1; end
        chk("pre_reset_valid", {63'd0, res_valid}, 64'd1);
        #2 rst_n = 1'b0;
        exp_q.delete();
        #1;
        chk("mid_rst_valid", {63'd0, res_valid}, 64'd0);
        chk("mid_rst_busy", {63'd0, busy}, 64'd0);
        chk("mid_rst_alu_op", 64'(alu_op), 64'd0);
        chk("mid_rst_alu_a", 64'(alu_a), 64'd0);
        chk("mid_rst_count", 64'(count), 64'd0);
        @(posedge clk); #1 rst_n = 1'b1;
        res_ready = 1'b1;
        kick(32'd7, 32'd1, 2, 4);
        wait_done(n, 1'b0);
        chk("post_rst_count", 64'(count), 64'd3);
        drain();

        s3_start = 1'b1;
        @(posedge clk); #1 s3_start = 1'b0;
        prev = 0; nchg = 0; first_t = 0; last_t = 0;
        for (int i = 1; i <= 40; i++) begin
            @(posedge clk); #1;
            if (int'(s3_alu_op) != prev) begin
                if (nchg == 0) first_t = i;
                else chk("settle3_spacing", 64'(i - last_t), 64'd4);
                last_t = i;
                nchg++;
                prev = int'(s3_alu_op);
            end
        end
        chk("settle3_first_change", 64'(first_t), 64'd4);
        chk("settle3_changes", 64'(nchg), 64'd3);
        chk("settle3_count", 64'(s3_count), 64'd4);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
